// File: rtl/block_decoder_if.sv
// Handshake bundle for block_decoder: header in, delta beats in, reconstructed block out.
// slave  = decoder side (drives hdr_ready, d_ready, out_valid, pixels, err).
// master = surrounding logic (drives hdr_valid, h, d_valid, d_delta, out_ready).
interface block_decoder_if #(
  parameter int NPIX    = 32,
  parameter int DELTA_W = 4
) ();

  // Header channel: [47:44] skip (44=R .. 47=A), [43:12] min_r/g/b/a, [11:0] unused.
  logic                             hdr_valid;
  logic                             hdr_ready;
  logic [47:0]                      h;

  // Delta channel: one beat per pixel, index 0=R, 1=G, 2=B, 3=A.
  logic                             d_valid;
  logic                             d_ready;
  logic [3:0][DELTA_W-1:0]          d_delta;

  // Output channel: whole block presented at once, pixels[i][c] in header channel order.
  logic                             out_valid;
  logic                             out_ready;
  logic [NPIX-1:0][3:0][7:0]        pixels;
  logic                             err;

  modport master (
    output hdr_valid, h, d_valid, d_delta, out_ready,
    input  hdr_ready, d_ready, out_valid, pixels, err
  );

  modport slave (
    input  hdr_valid, h, d_valid, d_delta, out_ready,
    output hdr_ready, d_ready, out_valid, pixels, err
  );

endinterface

// File: rtl/block_decoder.sv
// Rebuilds one NPIX-pixel RGBA block from a 48-bit header (skip mask + per-channel mins) and NPIX delta beats.
// Latency: header accepted at cycle 0, beats from cycle 1, out_valid at cycle NPIX+1 with no stalls.
// Backpressure: one block in flight; ready signals are registered and depend only on the FSM state.
//
// Ports: clk, rst_n (async active-low), bus (block_decoder_if.slave: hdr_*, d_*, out_*, pixels, err).
module block_decoder #(
  parameter int NPIX    = 32,
  parameter int DELTA_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  block_decoder_if.slave bus
);

  localparam int CW = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [3:0]                skip_q;
  logic [3:0][7:0]           min_q;
  logic [NPIX-1:0][3:0][7:0] pix_q;
  logic                      hdr_rdy_q;
  logic                      d_rdy_q;
  logic                      out_vld_q;
  logic                      err_q;

  // Candidate pixel for the current beat and whether any channel wrapped.
  logic [3:0][8:0]           sum9;
  logic [3:0][7:0]           pix_nxt;
  logic                      ovf_nxt;

  // Header bits [11:0] carry nothing the decoder uses.
  logic                      unused_hdr_lsbs;
  assign unused_hdr_lsbs = ^bus.h[11:0];

  always_comb begin
    sum9    = '0;
    pix_nxt = '0;
    ovf_nxt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      // Skipped channels reproduce the min exactly; their delta field is still
      // present in the beat but carries no information.
      sum9[c]    = {1'b0, min_q[c]} + (skip_q[c] ? 9'd0 : 9'(bus.d_delta[c]));
      pix_nxt[c] = sum9[c][7:0];
      ovf_nxt    = ovf_nxt | sum9[c][8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      skip_q    <= '0;
      min_q     <= '0;
      pix_q     <= '0;
      hdr_rdy_q <= 1'b1;
      d_rdy_q   <= 1'b0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // hdr_ready is high throughout IDLE, so hdr_valid alone completes the handshake.
          if (bus.hdr_valid) begin
            skip_q    <= bus.h[47:44];
            min_q     <= {bus.h[19:12], bus.h[27:20], bus.h[35:28], bus.h[43:36]};
            cnt       <= '0;
            err_q     <= 1'b0;
            state     <= DATA;
            hdr_rdy_q <= 1'b0;
            d_rdy_q   <= 1'b1;
          end
        end

        DATA: begin
          // d_ready is high throughout DATA; a gap simply holds everything.
          if (bus.d_valid) begin
            pix_q[cnt] <= pix_nxt;
            if (ovf_nxt) begin
              err_q <= 1'b1;
            end
            if (cnt == CW'(NPIX - 1)) begin
              cnt       <= '0;
              state     <= OUT;
              d_rdy_q   <= 1'b0;
              out_vld_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        OUT: begin
          // Pixels and err are left in place after the handshake; only the
          // next block's beats overwrite them.
          if (bus.out_ready) begin
            state     <= IDLE;
            out_vld_q <= 1'b0;
            hdr_rdy_q <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          hdr_rdy_q <= 1'b1;
          d_rdy_q   <= 1'b0;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hdr_ready = hdr_rdy_q;
  assign bus.d_ready   = d_rdy_q;
  assign bus.out_valid = out_vld_q;
  assign bus.pixels    = pix_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_block_decoder.sv
// Self-checking bench for block_decoder: directed block sequence with random deltas/mins.
// Reference model rebuilds each pixel from header mins, skip mask and deltas with integer arithmetic.
// Covers reset, skip-all, patterned deltas, overflow/err, gapped beats, output stall, mid-block reset.
module tb_block_decoder;

  localparam int NPIX = 32;
  localparam int DW   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  block_decoder_if #(.NPIX(NPIX), .DELTA_W(DW)) bus ();

  block_decoder #(.NPIX(NPIX), .DELTA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [3:0]      m_skip;
  int              m_min [4];
  bit              exp_err;
  logic [3:0][7:0] exp_pix [NPIX];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input int i, input logic [3:0][DW-1:0] dl);
    for (int c = 0; c < 4; c++) begin
      int v;
      v = m_min[c] + (m_skip[c] ? 0 : int'(dl[c]));
      if (v > 255) begin
        exp_err = 1'b1;
        v = v - 256;
      end
      exp_pix[i][c] = v[7:0];
    end
  endtask

  task automatic send_hdr(input logic [3:0] skip, input logic [7:0] mr, input logic [7:0] mg,
                          input logic [7:0] mb, input logic [7:0] ma, output int acc_edge);
    int t;
    t = 0;
    bus.h         = {skip, mr, mg, mb, ma, 12'($urandom)};
    bus.hdr_valid = 1'b1;
    while (!bus.hdr_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("hdr_wait", bus.hdr_ready, 1);
    @(posedge clk); #1;
    acc_edge      = edge_cnt;
    bus.hdr_valid = 1'b0;
    m_skip  = skip;
    m_min[0] = int'(mr);
    m_min[1] = int'(mg);
    m_min[2] = int'(mb);
    m_min[3] = int'(ma);
    exp_err = 1'b0;
  endtask

  // mode 0: random deltas; 1: R=i%16,G=15,B=0,A=1; 2: random with R delta of beat 5 forced to 0xA
  task automatic send_beats(input int mode, input bit gap, input int nbeats, output int last_edge);
    logic [3:0][DW-1:0] dl;
    int t;
    for (int i = 0; i < nbeats; i++) begin
      if (gap) begin
        bus.d_valid = 1'b0;
        bus.d_delta = (4*DW)'($urandom);
        @(posedge clk); #1;
      end
      for (int c = 0; c < 4; c++) dl[c] = DW'($urandom);
      if (mode == 1) begin
        dl[0] = DW'(i % 16);
        dl[1] = DW'(15);
        dl[2] = DW'(0);
        dl[3] = DW'(1);
      end
      if (mode == 2 && i == 5) dl[0] = DW'(4'hA);
      model_beat(i, dl);
      bus.d_delta = dl;
      bus.d_valid = 1'b1;
      t = 0;
      while (!bus.d_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!bus.d_ready) check("beat_wait", bus.d_ready, 1);
      @(posedge clk); #1;
      last_edge = edge_cnt;
    end
    bus.d_valid = 1'b0;
  endtask

  // Entered right after the edge that accepted the last beat.
  task automatic check_out(input string tag, input int hold);
    logic [NPIX-1:0][3:0][7:0] snap;
    check({tag, "_ovld"}, bus.out_valid, 1);
    check({tag, "_drdy"}, bus.d_ready, 0);
    check({tag, "_hrdy"}, bus.hdr_ready, 0);
    check({tag, "_err"}, bus.err, exp_err);
    for (int i = 0; i < NPIX; i++)
      check($sformatf("%s_pix%0d", tag, i), bus.pixels[i], exp_pix[i]);
    snap = bus.pixels;
    bus.out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      bus.hdr_valid = (k == 3);
      bus.h         = 48'($urandom) ^ {16'($urandom), 32'h0};
      bus.d_valid   = (k == 5);
      bus.d_delta   = (4*DW)'($urandom);
      @(posedge clk); #1;
      check($sformatf("%s_hold_ovld%0d", tag, k), bus.out_valid, 1);
      check($sformatf("%s_hold_pix%0d", tag, k), bus.pixels === snap, 1);
      check($sformatf("%s_hold_hrdy%0d", tag, k), bus.hdr_ready, 0);
    end
    bus.hdr_valid = 1'b0;
    bus.d_valid   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_done_ovld"}, bus.out_valid, 0);
    check({tag, "_done_hrdy"}, bus.hdr_ready, 1);
    check({tag, "_done_drdy"}, bus.d_ready, 0);
    check({tag, "_done_pix"}, bus.pixels === snap, 1);
  endtask

  initial begin
    int h_e;
    int l_e;
    bus.hdr_valid = 1'b0;
    bus.h         = '0;
    bus.d_valid   = 1'b0;
    bus.d_delta   = '0;
    bus.out_ready = 1'b0;

    // Reset values.
    #12;
    check("rst_hrdy", bus.hdr_ready, 1);
    check("rst_drdy", bus.d_ready, 0);
    check("rst_ovld", bus.out_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_pix", bus.pixels === '0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All channels skipped: deltas ignored, latency NPIX edges from header to OUT.
    send_hdr(4'hF, 8'd10, 8'd20, 8'd30, 8'd255, h_e);
    check("t1_drdy", bus.d_ready, 1);
    check("t1_hrdy", bus.hdr_ready, 0);
    send_beats(0, 1'b0, NPIX, l_e);
    check("t1_latency", l_e - h_e, NPIX);
    check("t1_pix0_direct", bus.pixels[0], 32'hFF1E140A);
    check_out("t1", 0);

    // Patterned deltas on mins of 0x40.
    send_hdr(4'h0, 8'h40, 8'h40, 8'h40, 8'h40, h_e);
    send_beats(1, 1'b0, NPIX, l_e);
    check("t2_pix7_direct", bus.pixels[7], 32'h41404F47);
    check_out("t2", 0);

    // Red overflow on beat 5.
    send_hdr(4'h0, 8'hF8, 8'($urandom_range(0, 240)), 8'($urandom), 8'($urandom), h_e);
    send_beats(2, 1'b0, NPIX, l_e);
    check("t3_pix5_r", bus.pixels[5][0], 8'h02);
    check("t3_err_set", bus.err, 1);
    check_out("t3", 0);

    // Next header clears err; beats arrive every other cycle.
    send_hdr(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), h_e);
    check("t4_err_clr", bus.err, 0);
    send_beats(0, 1'b1, NPIX, l_e);
    check("t4_latency", l_e - h_e, 2 * NPIX);
    check_out("t4", 0);

    // Output stalled 10 cycles with stray header/delta pulses.
    send_hdr(4'b0101, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), h_e);
    send_beats(0, 1'b0, NPIX, l_e);
    check_out("t5", 10);

    // Reset in the middle of a block.
    send_hdr(4'h0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), h_e);
    send_beats(0, 1'b0, 12, l_e);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ovld", bus.out_valid, 0);
    check("t6_rst_hrdy", bus.hdr_ready, 1);
    check("t6_rst_drdy", bus.d_ready, 0);
    check("t6_rst_err", bus.err, 0);
    check("t6_rst_pix", bus.pixels === '0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_hdr(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), h_e);
    send_beats(0, 1'b0, NPIX, l_e);
    check("t6_latency", l_e - h_e, NPIX);
    check_out("t6", 0);

    // A few fully random blocks, including high mins that tend to overflow.
    for (int b = 0; b < 3; b++) begin
      send_hdr(4'($urandom), 8'($urandom_range(200, 255)), 8'($urandom), 8'($urandom), 8'($urandom), h_e);
      send_beats(0, b[0], NPIX, l_e);
      check_out($sformatf("t7_%0d", b), b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/block_decoder.md
Name: block_decoder

Overview:
- Receiver end of the block compression path: rebuilds one 32-pixel RGBA block from a 48-bit block header plus a stream of per-pixel channel deltas.
- Header format matches the compressor's header generator.
- Sits between the link/payload deserializer and the frame writer.
- One block in flight at a time; header, delta and output interfaces each use valid/ready.

Parameters:
- NPIX, 32, pixels per block; the delta counter is $clog2(NPIX) bits.
- DELTA_W, 4, width of each per-channel unsigned delta in a beat (1..8).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- hdr_valid  input  1  h holds a valid block header
- hdr_ready  output  1  decoder accepts header
- h  input  48  header: [47:44] skip bits (44=R, 45=G, 46=B, 47=A); [43:36] min_r, [35:28] min_g, [27:20] min_b, [19:12] min_a; [11:0] ignored
- d_valid  input  1  delta beat valid
- d_ready  output  1  decoder accepts delta beat
- d_delta  input  4 x DELTA_W  per-channel delta for the current pixel; index 0=R, 1=G, 2=B, 3=A
- out_valid  output  1  reconstructed block valid
- out_ready  input  1  consumer accepts block
- pixels  output  32 x 4 x 8  reconstructed block; pixels[i][c] uses the same channel order as the header
- err  output  1  overflow seen in the current block

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, latched header=0, pixel regs=0.
  - Outputs: hdr_ready=1, d_ready=0, out_valid=0, err=0.
- States: IDLE, DATA, OUT.
- IDLE:
  - hdr_ready=1, d_ready=0, out_valid=0.
  - On hdr_valid&hdr_ready: latch skip[3:0] and the four mins, clear counter and err, go to DATA next cycle.
- DATA:
  - d_ready=1, hdr_ready=0.
  - Each d_valid&d_ready beat writes pixel[counter] and increments counter.
  - Gaps (d_valid=0) hold all state.
  - On the beat with counter=NPIX-1, go to OUT next cycle; counter wraps to 0.
- Per-channel arithmetic for channel c:
  - If skip[c]=1: pixel[i][c]=min_c, and d_delta[c] is ignored.
  - Else: pixel[i][c]=min_c + zero-extended d_delta[c], as a 9-bit add.
  - If bit 8 of the sum is set, store the low 8 bits (wrap mod 256) and set err=1.
  - err is sticky until the next header is accepted.
- OUT:
  - out_valid=1, pixels and err stable; d_ready=0, hdr_ready=0.
  - On out_valid&out_ready, go to IDLE next cycle; pixels keep their value until overwritten.
- Latency:
  - Header accept at cycle 0; first delta beat accepted no earlier than cycle 1.
  - With no stalls, out_valid rises at cycle NPIX+1.
  - The next header is accepted no earlier than the cycle after the output handshake.
- hdr_valid while not in IDLE is ignored and not consumed. d_valid outside DATA is ignored.
- A skipped channel still occupies its DELTA_W field in each beat; a beat is always required per pixel, even if all four skip bits are set.
- pixels is fully registered; there is no combinational path from any input to any output. The ready signals depend only on state.
- Reset mid-block (DATA or OUT): the partial block is discarded, outputs return to reset values immediately, and the next header starts a fresh block.

Test Plan:
- Skip=4'hF, mins R=10 G=20 B=30 A=255, 32 beats of arbitrary deltas -> every pixel = (10,20,30,255), err=0, out_valid at cycle 33.
- Skip=0, mins all 8'h40, beat i deltas R=i%16, G=15, B=0, A=1 -> pixel[i]=(0x40+i%16, 0x4F, 0x40, 0x41), err=0.
- Skip=0, min_r=8'hF8, beat 5 R delta=4'hA -> pixel[5][0]=8'h02, err=1 at OUT; next header clears err to 0.
- d_valid toggled every other cycle -> 32 pixels still correct; out_valid rises one cycle after the 32nd accepted beat.
- out_ready held low 10 cycles in OUT -> out_valid and pixels stay stable; hdr_ready=0 and a hdr_valid pulse is not consumed; the handshake returns to IDLE next cycle.
- rst_n low after 12 beats -> out_valid=0, hdr_ready=1, d_ready=0 asynchronously; a new header plus 32 beats decodes correctly.
